// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM handshake state and the memory arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// Saturating wait counter for a granted RAM access; expired flags the last allowed grant cycle.
module arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CW'(TIMEOUT))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requesters onto one RAM port, data first, with timeout and sticky err.
// Optional MEMORY_ARBITER_PERF_EN adds icount/dcount completed-access counters.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
`ifdef MEMORY_ARBITER_PERF_EN
  ,
  output word_t     icount,
  output word_t     dcount
`endif
);

  arb_state_t state_reg, state_next;
  logic       ren_reg, ren_next, wen_reg, wen_next;
  word_t      addr_reg, addr_next, store_reg, store_next;
  logic       err_reg, err_next;
  logic       hit_access, hit_error, expired, timeout, finish;
  logic       tmr_clear, tmr_enable;

  assign hit_access = (ramstate == ACCESS);
  assign hit_error  = (ramstate == ERROR);
  assign timeout    = expired && !hit_access && !hit_error;
  assign finish     = hit_access || hit_error || timeout;
  assign tmr_clear  = (state_reg == IDLE);
  assign tmr_enable = (state_reg != IDLE) && !hit_access && !hit_error;
  assign err        = err_reg;

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (expired)
  );

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      ren_reg   <= 1'b0;
      wen_reg   <= 1'b0;
      addr_reg  <= '0;
      store_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ren_reg   <= ren_next;
      wen_reg   <= wen_next;
      addr_reg  <= addr_next;
      store_reg <= store_next;
      err_reg   <= err_next;
    end
  end

  // An abort (enable dropped) takes priority over a same-cycle completion.
  always_comb begin
    state_next = state_reg;
    ren_next   = ren_reg;
    wen_next   = wen_reg;
    addr_next  = addr_reg;
    store_next = store_reg;
    err_next   = err_reg;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    case (state_reg)
      IDLE: begin
        if (dREN || dWEN) begin
          state_next = DGRANT;
          ren_next   = dREN && !dWEN;
          wen_next   = dWEN;
          addr_next  = daddr;
          store_next = dstore;
        end else if (iREN) begin
          state_next = IGRANT;
          ren_next   = 1'b1;
          wen_next   = 1'b0;
          addr_next  = iaddr;
          store_next = '0;
        end
      end
      IGRANT: begin
        ramREN   = 1'b1;
        ramaddr  = addr_reg;
        ramstore = store_reg;
        if (!iREN) begin
          state_next = IDLE;
        end else if (finish) begin
          state_next = IDLE;
          iwait      = 1'b0;
          iload      = hit_access ? ramload : '0;
          err_next   = err_reg || !hit_access;
        end
      end
      DGRANT: begin
        ramREN   = ren_reg;
        ramWEN   = wen_reg;
        ramaddr  = addr_reg;
        ramstore = store_reg;
        if (!(dREN || dWEN)) begin
          state_next = IDLE;
        end else if (finish) begin
          state_next = IDLE;
          dwait      = 1'b0;
          dload      = hit_access ? ramload : '0;
          err_next   = err_reg || !hit_access;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MEMORY_ARBITER_PERF_EN
  word_t icount_reg, dcount_reg;
  logic  i_ok, d_ok;

  assign i_ok = (state_reg == IGRANT) && iREN && hit_access;
  assign d_ok = (state_reg == DGRANT) && (dREN || dWEN) && hit_access;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      icount_reg <= '0;
      dcount_reg <= '0;
    end else begin
      if (i_ok) icount_reg <= icount_reg + 32'd1;
      if (d_ok) dcount_reg <= dcount_reg + 32'd1;
    end
  end

  assign icount = icount_reg;
  assign dcount = dcount_reg;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: latency, priority, no-preemption, abort, timeout, ERROR, reset.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic      CLK, nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, iload, dload;
  logic      iwait, dwait, ramREN, ramWEN, err;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
`ifdef MEMORY_ARBITER_PERF_EN
  word_t     icount, dcount;
`endif

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.TIMEOUT(64)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
`ifdef MEMORY_ARBITER_PERF_EN
    ,
    .icount   (icount),
    .dcount   (dcount)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One-cycle-latency access: grant, ACCESS immediately, then release.
  task automatic do_access(input bit is_d, input word_t addr, input word_t data);
    if (is_d) begin
      dREN = 1'b1; daddr = addr;
    end else begin
      iREN = 1'b1; iaddr = addr;
    end
    ramstate = FREE;
    tick();
    ramstate = ACCESS; ramload = data; #1;
    check(is_d ? "acc_dload" : "acc_iload", is_d ? dload : iload, data);
    check(is_d ? "acc_dwait" : "acc_iwait", 32'(is_d ? dwait : iwait), 32'd0);
    check("acc_addr", ramaddr, addr);
    tick();
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE; ramload = '0; #1;
    check("acc_idle", 32'(ramREN), 32'd0);
    $display("txn %s addr=0x%08h load=0x%08h", is_d ? "D" : "I", addr, data);
  endtask

  initial begin
    int early;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #2;
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    tick();
    tick();
    nRST = 1'b1;
    tick();

    // Instruction read, two BUSY cycles then ACCESS
    iREN = 1'b1; iaddr = 32'h100; #1;
    check("t1_c0_idle", 32'(ramREN), 32'd0);
    tick(); ramstate = BUSY; #1;
    check("t1_c1_addr", ramaddr, 32'h100);
    check("t1_c1_ren", 32'(ramREN), 32'd1);
    check("t1_c1_iwait", 32'(iwait), 32'd1);
    tick(); #1;
    check("t1_c2_addr", ramaddr, 32'h100);
    check("t1_c2_iload", iload, 32'd0);
    tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    check("t1_c3_iwait", 32'(iwait), 32'd0);
    check("t1_c3_iload", iload, 32'hDEADBEEF);
    check("t1_c3_dwait", 32'(dwait), 32'd1);
    tick(); iREN = 1'b0; ramstate = FREE; #1;
    check("t1_c4_idle", 32'(ramREN), 32'd0);
    check("t1_c4_iload", iload, 32'd0);
    check("t1_c4_iwait", 32'(iwait), 32'd1);
    $display("txn I addr=0x00000100 load=0xdeadbeef latency=3");
    ramload = '0;
    tick();

    // Simultaneous instruction read and data write: data first
    iREN = 1'b1; iaddr = 32'h300; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55;
    tick(); ramstate = ACCESS; #1;
    check("t2_ramWEN", 32'(ramWEN), 32'd1);
    check("t2_ramREN", 32'(ramREN), 32'd0);
    check("t2_ramaddr", ramaddr, 32'h200);
    check("t2_ramstore", ramstore, 32'h55);
    check("t2_dwait", 32'(dwait), 32'd0);
    check("t2_iwait", 32'(iwait), 32'd1);
    tick(); dWEN = 1'b0; ramstate = FREE; #1;
    check("t2_turn_ren", 32'(ramREN), 32'd0);
    check("t2_turn_addr", ramaddr, 32'd0);
    tick(); ramstate = ACCESS; ramload = 32'hCAFE; #1;
    check("t2_i_addr", ramaddr, 32'h300);
    check("t2_i_iwait", 32'(iwait), 32'd0);
    check("t2_i_iload", iload, 32'hCAFE);
    tick(); iREN = 1'b0; ramstate = FREE; ramload = '0; #1;
    check("t2_end_idle", 32'(ramREN), 32'd0);
    $display("txn D-write addr=0x00000200 then I addr=0x00000300");

    // Data request arrives mid-IGRANT; no preemption
    iREN = 1'b1; iaddr = 32'h400;
    tick(); ramstate = BUSY; dREN = 1'b1; daddr = 32'h500; #1;
    check("t3_c1_addr", ramaddr, 32'h400);
    check("t3_c1_dwait", 32'(dwait), 32'd1);
    tick(); #1;
    check("t3_c2_addr", ramaddr, 32'h400);
    check("t3_c2_dwait", 32'(dwait), 32'd1);
    tick(); #1;
    check("t3_c3_dwait", 32'(dwait), 32'd1);
    tick(); ramstate = ACCESS; ramload = 32'h11; #1;
    check("t3_c4_iwait", 32'(iwait), 32'd0);
    check("t3_c4_iload", iload, 32'h11);
    check("t3_c4_dwait", 32'(dwait), 32'd1);
    tick(); iREN = 1'b0; ramstate = FREE; #1;
    check("t3_c5_idle", 32'(ramREN), 32'd0);
    check("t3_c5_dwait", 32'(dwait), 32'd1);
    tick(); ramstate = ACCESS; ramload = 32'h22; #1;
    check("t3_c6_addr", ramaddr, 32'h500);
    check("t3_c6_ren", 32'(ramREN), 32'd1);
    check("t3_c6_dwait", 32'(dwait), 32'd0);
    check("t3_c6_dload", dload, 32'h22);
    tick(); dREN = 1'b0; ramstate = FREE; ramload = '0; #1;
    $display("txn I addr=0x00000400 then D addr=0x00000500");

    // Abort: instruction enable dropped while BUSY
    iREN = 1'b1; iaddr = 32'h700;
    tick(); ramstate = BUSY; #1;
    check("ab_ren", 32'(ramREN), 32'd1);
    tick(); iREN = 1'b0; ramload = 32'h99; #1;
    check("ab_iwait", 32'(iwait), 32'd1);
    check("ab_iload", iload, 32'd0);
    tick(); ramstate = FREE; ramload = '0; #1;
    check("ab_idle", 32'(ramREN), 32'd0);
    check("ab_err", 32'(err), 32'd0);
    $display("txn I addr=0x00000700 aborted");

    // Timeout: data read held BUSY
    dREN = 1'b1; daddr = 32'h600; ramstate = BUSY; ramload = 32'hBAD;
    early = 0;
    for (int g = 1; g <= 63; g++) begin
      tick(); #1;
      if (dwait == 1'b0) early++;
    end
    check("tmo_early", 32'(early), 32'd0);
    tick(); #1;
    check("tmo_dwait", 32'(dwait), 32'd0);
    check("tmo_dload", dload, 32'd0);
    check("tmo_err_pre", 32'(err), 32'd0);
    tick(); dREN = 1'b0; ramstate = FREE; ramload = '0; #1;
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_idle", 32'(ramREN), 32'd0);
    $display("txn D addr=0x00000600 timeout");
    do_access(1'b0, 32'hA00, 32'h42);
    check("tmo_err_sticky", 32'(err), 32'd1);

    // Reset during a data write grant
    dWEN = 1'b1; daddr = 32'h800; dstore = 32'h99;
    tick(); ramstate = BUSY; #1;
    check("rs_wen_before", 32'(ramWEN), 32'd1);
    nRST = 1'b0; #1;
    check("rs_wen_now", 32'(ramWEN), 32'd0);
    check("rs_dwait", 32'(dwait), 32'd1);
    dWEN = 1'b0; ramstate = FREE;
    tick(); nRST = 1'b1; #1;
    check("rs_idle", 32'(ramREN), 32'd0);
    check("rs_err", 32'(err), 32'd0);
    $display("txn D-write addr=0x00000800 reset mid-access");
    tick();

    // ERROR completion
    dREN = 1'b1; daddr = 32'h900;
    tick(); ramstate = ERROR; ramload = 32'h77; #1;
    check("er_dwait", 32'(dwait), 32'd0);
    check("er_dload", dload, 32'd0);
    tick(); dREN = 1'b0; ramstate = FREE; ramload = '0; #1;
    check("er_err", 32'(err), 32'd1);
    check("er_idle", 32'(ramREN), 32'd0);
    $display("txn D addr=0x00000900 ERROR");

    do_access(1'b0, 32'h1000, 32'h1);
    do_access(1'b1, 32'h2000, 32'h2);
    do_access(1'b0, 32'h1004, 32'h3);
    do_access(1'b1, 32'h2004, 32'h4);
    do_access(1'b0, 32'h1008, 32'h5);
`ifdef MEMORY_ARBITER_PERF_EN
    check("perf_icount", icount, 32'd3);
    check("perf_dcount", dcount, 32'd2);
`endif
    check("final_err", 32'(err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
